alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single core ALU, driven by alu_control codes, between the CPU execute path and the ML coprocessor.
- Arbitrates the two requesters, sequences one operation at a time through the combinational ALU, registers the result and returns it to the winning requester.
- Sits between the two requesters and the ALU instance.

Parameters:
- WIDTH, 32, operand and result width.
- RR_MODE, 0, 0 = CPU fixed priority with starvation guard; 1 = round-robin.
- MAX_WAIT, 4, stalled coprocessor cycles before it is forced ahead of the CPU (RR_MODE=0 only); range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  CPU request accepted this cycle.
- cpu_ctrl  in  4  CPU ALU control code.
- cpu_a, cpu_b  in  WIDTH  CPU operands.
- cpu_resp_valid  out  1  one-cycle result strobe.
- cpu_result  out  WIDTH  registered result.
- cpu_zero  out  1  registered zero flag.
- cop_req_valid, cop_req_ready, cop_ctrl, cop_a, cop_b, cop_resp_valid, cop_result, cop_zero: same as the cpu_* ports, for the coprocessor.
- alu_ctrl  out  4  to the ALU.
- alu_a, alu_b  out  WIDTH  to the ALU.
- alu_result  in  WIDTH  from the ALU (combinational).
- alu_zero  in  1  from the ALU.
- resp_err  out  1  illegal control code flag; valid with either resp_valid.
- busy  out  1  high while in EXEC.

Behaviour:
- Reset values: all outputs 0, except alu_ctrl = 4'b0010 (ADD).
- Reset register values: state = IDLE, wait_cnt = 0, last_grant = COP, so the CPU wins the first tie.
- FSM state IDLE:
  - grant is computed combinationally.
  - The winner's req_ready = 1 (loser's = 0).
  - A handshake is valid&&ready; on it, latch ctrl/a/b and the owner, then go to EXEC.
  - With no valid request, stay in IDLE.
- FSM state EXEC (exactly one cycle):
  - alu_ctrl/alu_a/alu_b are driven from the latched registers.
  - Both req_ready = 0.
  - At the end of the cycle, capture alu_result/alu_zero into the owner's result/zero registers.
  - Go to IDLE.
- Outside EXEC: alu_a = alu_b = 0 and alu_ctrl = 0010.
- Response:
  - The owner's resp_valid = 1 for exactly the cycle after EXEC.
  - result/zero hold until that requester's next response.
  - No backpressure on responses.
  - The same IDLE cycle may accept a new request.
- Latency: handshake at edge N; resp_valid is high in cycle N+2. Throughput is one op per 2 cycles.
- Legal codes: 0000, 0001, 0010, 0110, 0111, 1000, 1001, 1010, 1011, 1100.
- Illegal code:
  - The op still occupies EXEC, but alu_ctrl is forced to 0010 with zero operands.
  - The captured result = 0, zero = 1, resp_err = 1 with the resp_valid.
  - Otherwise resp_err = 0.
- Arbitration, RR_MODE=0:
  - The CPU wins ties, unless wait_cnt == MAX_WAIT, in which case the coprocessor wins.
  - wait_cnt increments each cycle cop_req_valid=1 without a coprocessor handshake, saturating at MAX_WAIT.
  - wait_cnt clears on a coprocessor handshake or when cop_req_valid=0.
- Arbitration, RR_MODE=1:
  - On a tie, grant the requester that is not last_grant.
  - last_grant updates on every handshake.
  - wait_cnt is unused and held at 0.
- Single requester: granted immediately in either mode.
- Requesters must hold valid/ctrl/operands stable until ready. The arbiter samples only on the handshake edge; later input changes do not affect the in-flight op.
- Reset mid-operation:
  - Asynchronous reset in EXEC aborts the op; no resp_valid follows.
  - Results clear to 0 and state returns to IDLE immediately.

Test Plan:
- CPU only, ctrl=0010, a=5, b=7, handshake at edge N -> alu_ctrl=0010/alu_a=5/alu_b=7 during EXEC; cpu_resp_valid=1 in cycle N+2 with cpu_result=12, cpu_zero=0, resp_err=0.
- Coprocessor SUB 9-9 (0110), then SLT 3<8 (0111) back-to-back -> responses 2 cycles apart: result 0/zero 1, then result 1/zero 0.
- RR_MODE=0, both valid continuously, CPU issuing ADD ops, MAX_WAIT=4 -> first 2 grants go to the CPU; once wait_cnt reaches 4, the coprocessor is granted on the next IDLE cycle and wait_cnt returns to 0.
- RR_MODE=1, both valid continuously -> grants alternate CPU, COP, CPU, COP; each resp_valid is routed only to its owner.
- Illegal code 4'b1111 from the CPU with a=1, b=2 -> alu_ctrl=0010 with zero operands in EXEC; cpu_result=0, cpu_zero=1, resp_err=1 with cpu_resp_valid.
- Assert rst during EXEC of a coprocessor SRA -> busy=0 and all outputs at reset values immediately; no cop_resp_valid follows; after release, the CPU wins the first tie.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, response and ALU bus bundle for the shared-ALU arbiter
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             cpu_req_valid;
   logic             cpu_req_ready;
   logic [3:0]       cpu_ctrl;
   logic [WIDTH-1:0] cpu_a;
   logic [WIDTH-1:0] cpu_b;
   logic             cpu_resp_valid;
   logic [WIDTH-1:0] cpu_result;
   logic             cpu_zero;

   logic             cop_req_valid;
   logic             cop_req_ready;
   logic [3:0]       cop_ctrl;
   logic [WIDTH-1:0] cop_a;
   logic [WIDTH-1:0] cop_b;
   logic             cop_resp_valid;
   logic [WIDTH-1:0] cop_result;
   logic             cop_zero;

   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   logic             resp_err;
   logic             busy;

   // Arbiter side
   modport slave (
      input  cpu_req_valid, cpu_ctrl, cpu_a, cpu_b,
      output cpu_req_ready, cpu_resp_valid, cpu_result, cpu_zero,
      input  cop_req_valid, cop_ctrl, cop_a, cop_b,
      output cop_req_ready, cop_resp_valid, cop_result, cop_zero,
      output alu_ctrl, alu_a, alu_b,
      input  alu_result, alu_zero,
      output resp_err, busy
   );

   // Requester / ALU side
   modport master (
      output cpu_req_valid, cpu_ctrl, cpu_a, cpu_b,
      input  cpu_req_ready, cpu_resp_valid, cpu_result, cpu_zero,
      output cop_req_valid, cop_ctrl, cop_a, cop_b,
      input  cop_req_ready, cop_resp_valid, cop_result, cop_zero,
      input  alu_ctrl, alu_a, alu_b,
      output alu_result, alu_zero,
      input  resp_err, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between the CPU and the ML coprocessor
module alu_share_arbiter #(
   parameter int WIDTH    = 32,
   parameter bit RR_MODE  = 1'b0,
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic {IDLE, EXEC} state_t;

   localparam logic       OWN_CPU  = 1'b0;
   localparam logic       OWN_COP  = 1'b1;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   state_t           state, state_nx;
   logic [3:0]       wait_cnt;
   logic             last_grant;
   logic             owner_q;
   logic             illegal_q;
   logic [3:0]       ctrl_q;
   logic [WIDTH-1:0] a_q, b_q;

   logic             tie_cop, grant_cop;
   logic             cpu_ready_c, cop_ready_c;
   logic             cpu_hs, cop_hs;

   logic             cpu_resp_q, cop_resp_q, err_q;
   logic [WIDTH-1:0] cpu_result_q, cop_result_q;
   logic             cpu_zero_q, cop_zero_q;

   function automatic logic is_legal(input logic [3:0] c);
      case (c)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
         4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: is_legal = 1'b1;
         default:                                     is_legal = 1'b0;
      endcase
   endfunction

   // Tie-break and grant: fixed CPU priority with a starvation guard, or alternate on ties
   always_comb begin
      if (RR_MODE) tie_cop = (last_grant == OWN_CPU);
      else         tie_cop = (wait_cnt == WAIT_MAX);
      grant_cop = bus.cop_req_valid && (!bus.cpu_req_valid || tie_cop);
   end

   assign cpu_ready_c = (state == IDLE) && !rst && bus.cpu_req_valid && !grant_cop;
   assign cop_ready_c = (state == IDLE) && !rst && grant_cop;
   assign cpu_hs      = bus.cpu_req_valid && cpu_ready_c;
   assign cop_hs      = bus.cop_req_valid && cop_ready_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and ALU drive; illegal codes run as ADD 0+0
   always_comb begin
      state_nx     = state;
      bus.alu_ctrl = CTRL_ADD;
      bus.alu_a    = '0;
      bus.alu_b    = '0;
      bus.busy     = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_hs || cop_hs) state_nx = EXEC;
         end
         EXEC: begin
            bus.busy = 1'b1;
            if (!illegal_q) begin
               bus.alu_ctrl = ctrl_q;
               bus.alu_a    = a_q;
               bus.alu_b    = b_q;
            end
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the winning request and its owner on the handshake edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         owner_q    <= OWN_CPU;
         illegal_q  <= 1'b0;
         last_grant <= OWN_COP;
      end else if (cpu_hs || cop_hs) begin
         ctrl_q     <= cop_hs ? bus.cop_ctrl : bus.cpu_ctrl;
         a_q        <= cop_hs ? bus.cop_a    : bus.cpu_a;
         b_q        <= cop_hs ? bus.cop_b    : bus.cpu_b;
         illegal_q  <= !is_legal(cop_hs ? bus.cop_ctrl : bus.cpu_ctrl);
         owner_q    <= cop_hs;
         last_grant <= cop_hs;
      end
   end

   // Coprocessor starvation counter, saturating at MAX_WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                wait_cnt <= '0;
      else if (RR_MODE)                       wait_cnt <= '0;
      else if (cop_hs || !bus.cop_req_valid)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)          wait_cnt <= wait_cnt + 4'd1;
   end

   // Capture the ALU output into the owner's result registers and raise a one-cycle strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_resp_q   <= 1'b0;
         cop_resp_q   <= 1'b0;
         err_q        <= 1'b0;
         cpu_result_q <= '0;
         cpu_zero_q   <= 1'b0;
         cop_result_q <= '0;
         cop_zero_q   <= 1'b0;
      end else begin
         cpu_resp_q <= (state == EXEC) && (owner_q == OWN_CPU);
         cop_resp_q <= (state == EXEC) && (owner_q == OWN_COP);
         err_q      <= (state == EXEC) && illegal_q;
         if (state == EXEC && owner_q == OWN_CPU) begin
            cpu_result_q <= illegal_q ? '0   : bus.alu_result;
            cpu_zero_q   <= illegal_q ? 1'b1 : bus.alu_zero;
         end
         if (state == EXEC && owner_q == OWN_COP) begin
            cop_result_q <= illegal_q ? '0   : bus.alu_result;
            cop_zero_q   <= illegal_q ? 1'b1 : bus.alu_zero;
         end
      end
   end

   assign bus.cpu_req_ready  = cpu_ready_c;
   assign bus.cop_req_ready  = cop_ready_c;
   assign bus.cpu_resp_valid = cpu_resp_q;
   assign bus.cop_resp_valid = cop_resp_q;
   assign bus.cpu_result     = cpu_result_q;
   assign bus.cop_result     = cop_result_q;
   assign bus.cpu_zero       = cpu_zero_q;
   assign bus.cop_zero       = cop_zero_q;
   assign bus.resp_err       = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for the shared-ALU arbiter in both arbitration modes
module tb_alu_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.WIDTH(32)) b0 ();
   alu_share_arbiter_if #(.WIDTH(32)) b1 ();

   alu_share_arbiter #(.WIDTH(32), .RR_MODE(1'b0), .MAX_WAIT(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   alu_share_arbiter #(.WIDTH(32), .RR_MODE(1'b1), .MAX_WAIT(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   // Stand-in for the core ALU
   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'b0000: alu_f = a & b;
         4'b0001: alu_f = a | b;
         4'b0010: alu_f = a + b;
         4'b0110: alu_f = a - b;
         4'b0111: alu_f = {31'b0, $signed(a) < $signed(b)};
         4'b1000: alu_f = a ^ b;
         4'b1001: alu_f = a << b[4:0];
         4'b1010: alu_f = a >> b[4:0];
         4'b1011: alu_f = $unsigned($signed(a) >>> b[4:0]);
         4'b1100: alu_f = ~(a | b);
         default: alu_f = 32'hDEAD_BEEF;
      endcase
   endfunction

   assign b0.alu_result = alu_f(b0.alu_ctrl, b0.alu_a, b0.alu_b);
   assign b0.alu_zero   = (b0.alu_result == 32'd0);
   assign b1.alu_result = alu_f(b1.alu_ctrl, b1.alu_a, b1.alu_b);
   assign b1.alu_zero   = (b1.alu_result == 32'd0);

   typedef struct {
      bit          who;
      logic [31:0] res;
      logic        z;
      logic        err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   bit   glog0[$];
   bit   glog1[$];
   int   rt0[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic cv, input logic ov, input logic [31:0] cr,
                      input logic [31:0] co, input logic cz, input logic oz, input logic er);
      exp_t e;
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL d%0d_unexpected_resp: got cpu_v=%0b cop_v=%0b expected no response", d, cv, ov);
      end else begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         check($sformatf("d%0d_resp_owner", d), {cv, ov}, e.who ? 2'b01 : 2'b10);
         check($sformatf("d%0d_resp_result", d), ov ? co : cr, e.res);
         check($sformatf("d%0d_resp_zero", d), ov ? oz : cz, e.z);
         check($sformatf("d%0d_resp_err", d), er, e.err);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (b0.cpu_resp_valid || b0.cop_resp_valid)) begin
         rt0.push_back(cyc);
         mon(0, b0.cpu_resp_valid, b0.cop_resp_valid, b0.cpu_result, b0.cop_result,
             b0.cpu_zero, b0.cop_zero, b0.resp_err);
      end
   end

   always @(negedge clk) begin
      if (!rst && (b1.cpu_resp_valid || b1.cop_resp_valid))
         mon(1, b1.cpu_resp_valid, b1.cop_resp_valid, b1.cpu_result, b1.cop_result,
             b1.cpu_zero, b1.cop_zero, b1.resp_err);
   end

   task automatic set_req(input int d, input bit who, input logic v, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] bb);
      if (d == 0 && !who) begin
         b0.cpu_req_valid = v; b0.cpu_ctrl = c; b0.cpu_a = a; b0.cpu_b = bb;
      end else if (d == 0) begin
         b0.cop_req_valid = v; b0.cop_ctrl = c; b0.cop_a = a; b0.cop_b = bb;
      end else if (!who) begin
         b1.cpu_req_valid = v; b1.cpu_ctrl = c; b1.cpu_a = a; b1.cpu_b = bb;
      end else begin
         b1.cop_req_valid = v; b1.cop_ctrl = c; b1.cop_a = a; b1.cop_b = bb;
      end
   endtask

   function automatic logic rdy(input int d, input bit who);
      if (d == 0) return who ? b0.cop_req_ready : b0.cpu_req_ready;
      else        return who ? b1.cop_req_ready : b1.cpu_req_ready;
   endfunction

   // Issue one request (called at a falling edge), queue its expected response, check the EXEC cycle
   task automatic req(input int d, input bit who, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] bb, input logic [31:0] res, input logic z, input logic err);
      bit   ok = 1'b0;
      exp_t e;
      set_req(d, who, 1'b1, c, a, bb);
      for (int i = 0; i < 40; i++) begin
         #1;
         if (rdy(d, who)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL d%0d_req_timeout: who=%0d got no ready expected ready within 40 cycles", d, who);
         set_req(d, who, 1'b0, c, a, bb);
         return;
      end
      e.who = who; e.res = res; e.z = z; e.err = err;
      if (d == 0) begin q0.push_back(e); glog0.push_back(who); end
      else        begin q1.push_back(e); glog1.push_back(who); end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("d%0d_exec_busy", d), (d == 0) ? b0.busy : b1.busy, 1'b1);
      check($sformatf("d%0d_exec_alu_ctrl", d), (d == 0) ? b0.alu_ctrl : b1.alu_ctrl, err ? 4'b0010 : c);
      check($sformatf("d%0d_exec_alu_a", d), (d == 0) ? b0.alu_a : b1.alu_a, err ? 32'd0 : a);
      check($sformatf("d%0d_exec_alu_b", d), (d == 0) ? b0.alu_b : b1.alu_b, err ? 32'd0 : bb);
      set_req(d, who, 1'b0, c, a, bb);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_ready"}, b0.cpu_req_ready, 1'b0);
      check({tag, "_cop_ready"}, b0.cop_req_ready, 1'b0);
      check({tag, "_cpu_resp_valid"}, b0.cpu_resp_valid, 1'b0);
      check({tag, "_cop_resp_valid"}, b0.cop_resp_valid, 1'b0);
      check({tag, "_cpu_result"}, b0.cpu_result, 32'd0);
      check({tag, "_cop_result"}, b0.cop_result, 32'd0);
      check({tag, "_cpu_zero"}, b0.cpu_zero, 1'b0);
      check({tag, "_resp_err"}, b0.resp_err, 1'b0);
      check({tag, "_busy"}, b0.busy, 1'b0);
      check({tag, "_alu_ctrl"}, b0.alu_ctrl, 4'b0010);
      check({tag, "_alu_a"}, b0.alu_a, 32'd0);
      check({tag, "_alu_b"}, b0.alu_b, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bit exp_grant0 [5];
      bit exp_grant1 [4];
      exp_grant0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_grant1 = '{1'b0, 1'b1, 1'b0, 1'b1};
      set_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(0, 1, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1, 1'b0, 4'd0, 32'd0, 32'd0);

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // CPU ADD 5+7, latency and hold
      req(0, 0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      @(negedge clk);
      check("add_resp_strobe_n2", b0.cpu_resp_valid, 1'b1);
      @(negedge clk);
      check("add_resp_one_cycle", b0.cpu_resp_valid, 1'b0);
      check("add_result_hold", b0.cpu_result, 32'd12);

      // Coprocessor SUB then SLT back-to-back
      rt0.delete();
      req(0, 1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
      req(0, 1, 4'b0111, 32'd3, 32'd8, 32'd1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("b2b_resp_count", rt0.size(), 2);
      if (rt0.size() == 2) check("b2b_resp_spacing", rt0[1] - rt0[0], 2);

      // Illegal code from the CPU
      req(0, 0, 4'b1111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      check("err_cleared_after_resp", b0.resp_err, 1'b0);

      // Fixed priority with starvation guard
      glog0.delete();
      fork
         begin
            for (int i = 0; i < 4; i++)
               req(0, 0, 4'b0010, 32'd10 * (i + 1), i + 1, 32'd11 * (i + 1), 1'b0, 1'b0);
         end
         begin
            req(0, 1, 4'b0000, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, 1'b0);
         end
      join
      repeat (3) @(negedge clk);
      check("starve_grant_count", glog0.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < glog0.size()) check($sformatf("starve_grant_%0d", i), glog0[i], exp_grant0[i]);

      // Asynchronous reset during a coprocessor SRA
      set_req(0, 1, 1'b1, 4'b1011, 32'h8000_0000, 32'd4);
      #1;
      check("sra_cop_ready", b0.cop_req_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("sra_exec_busy", b0.busy, 1'b1);
      set_req(0, 1, 1'b0, 4'd0, 32'd0, 32'd0);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      glog0.delete();
      fork
         req(0, 0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
         req(0, 1, 4'b1011, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
      join
      repeat (3) @(negedge clk);
      check("postrst_grant_count", glog0.size(), 2);
      if (glog0.size() == 2) begin
         check("postrst_first_tie_cpu", glog0[0], 1'b0);
         check("postrst_second_cop", glog0[1], 1'b1);
      end

      // Round-robin alternation
      glog1.delete();
      fork
         begin
            req(1, 0, 4'b0001, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0);
            req(1, 0, 4'b1010, 32'h100, 32'd4, 32'h10, 1'b0, 1'b0);
         end
         begin
            req(1, 1, 4'b1000, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b0);
            req(1, 1, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
         end
      join
      repeat (4) @(negedge clk);
      check("rr_grant_count", glog1.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < glog1.size()) check($sformatf("rr_grant_%0d", i), glog1[i], exp_grant1[i]);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
